// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller with per-frame atomic commit
// Writes land in shadow; shadow copies to active when the last digit's SHOW ends.

module seg_scan_ctrl #(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int BLANK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [2:0]      wr_idx,
  input  logic [3:0]      wr_data,
  output logic [3:0]      dig_b,
  output logic [NDIG-1:0] an,
  output logic            frame_done
);

  localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [2:0]    LAST      = 3'(NDIG - 1);
  localparam logic [CW-1:0] SHOW_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK - 1);

  typedef enum logic {S_BLANK = 1'b0, S_SHOW = 1'b1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    shadow [NDIG];
  logic [3:0]    active [NDIG];
  logic          dwell_end, last_digit, commit, wr_fire;

  assign dwell_end  = (state == S_SHOW) ? (cnt == SHOW_END) : (cnt == BLANK_END);
  assign last_digit = (idx == LAST);
  assign commit     = (state == S_SHOW) && dwell_end && last_digit;
  assign wr_fire    = wr_valid && wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BLANK;
      cnt        <= '0;
      idx        <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= commit;
      if (state_nx != state) cnt <= '0;
      else                   cnt <= cnt + CW'(1);
      if (state == S_SHOW && dwell_end) idx <= last_digit ? 3'd0 : idx + 3'd1;
    end
  end

  always_comb begin
    state_nx = state;
    if (dwell_end) state_nx = (state == S_BLANK) ? S_SHOW : S_BLANK;
  end

  // The commit cycle stalls writes so a write and a commit never share an edge.
  always_comb begin
    wr_ready = !commit;
    an       = '1;
    dig_b    = 4'b0000;
    if (state == S_SHOW) begin
      for (int i = 0; i < NDIG; i++) begin
        if (idx == 3'(i)) begin
          an[i] = 1'b0;
          dig_b = active[i];
        end
      end
    end
  end

  // Out-of-range indices match no entry, so those writes are accepted and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) begin
        shadow[i] <= 4'b0000;
        active[i] <= 4'b0000;
      end
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (wr_fire && wr_idx == 3'(i)) shadow[i] <= wr_data;
        if (commit) active[i] <= shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed bench for seg_scan_ctrl with NDIG=4, DIV=3, BLANK=1

module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_idx = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic [3:0] dig_b;
  logic [3:0] an;
  logic       frame_done;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Frame 0 digit-select, one entry per cycle after reset release.
  logic [3:0] an_tbl [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                              4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

  // Packed per-digit expected codes: digit i at [4*i +: 4].
  localparam logic [15:0] E_ZERO = 16'h0000;
  localparam logic [15:0] E_A    = 16'h0B0D;
  localparam logic [15:0] E_B    = 16'hEB0D;
  localparam logic [15:0] E_C    = 16'hEBFD;

  seg_scan_ctrl #(.NDIG(4), .DIV(3), .BLANK(1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_data(wr_data), .dig_b(dig_b), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] exp_an(input int pos);
    logic [3:0] m;
    m = 4'b0001 << (pos / 4);
    return (pos % 4 == 0) ? 4'hF : ~m;
  endfunction

  function automatic logic [3:0] exp_dig(input int pos, input logic [15:0] e);
    return (pos % 4 == 0) ? 4'h0 : e[4*(pos/4) +: 4];
  endfunction

  task automatic scan(input logic [15:0] e, input int stop);
    int pos;
    do begin
      pos = cyc % 16;
      chk("scan_an", an, exp_an(pos));
      chk("scan_dig_b", dig_b, exp_dig(pos, e));
      chk("scan_wr_ready", wr_ready, pos != 15);
      chk("scan_frame_done", frame_done, pos == 0 && cyc > 0);
      step();
    end while (cyc % 16 != stop);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [3:0] data);
    wr_valid = 1'b1;
    wr_idx   = idx;
    wr_data  = data;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_dig_b", dig_b, 4'h0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    rst = 1'b0;
    cyc = 0;

    for (int c = 0; c < 16; c++) begin
      chk("f0_an", an, an_tbl[c]);
      chk("f0_dig_b", dig_b, 4'h0);
      chk("f0_frame_done", frame_done, 1'b0);
      step();
    end
    chk("f0_fd_c16", frame_done, 1'b1);

    wr(3'd0, 4'b1101);
    wr(3'd2, 4'b1011);
    scan(E_ZERO, 0);
    scan(E_A, 0);

    wr_idx = 3'd6;
    chk("oor_ready", wr_ready, 1'b1);
    wr(3'd6, 4'b1111);
    wr(3'd3, 4'b1001);
    wr(3'd3, 4'b1110);
    scan(E_A, 0);

    scan(E_B, 15);
    wr_valid = 1'b1;
    wr_idx   = 3'd1;
    wr_data  = 4'b1111;
    chk("stall_ready_low", wr_ready, 1'b0);
    step();
    chk("stall_ready_high", wr_ready, 1'b1);
    chk("stall_frame_done", frame_done, 1'b1);
    step();
    wr_valid = 1'b0;
    scan(E_B, 0);
    scan(E_C, 0);

    wr(3'd0, 4'b0001);
    scan(E_C, 10);
    #1;
    rst = 1'b1;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_dig_b", dig_b, 4'h0);
    chk("async_frame_done", frame_done, 1'b0);
    chk("async_wr_ready", wr_ready, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    scan(E_ZERO, 0);
    scan(E_ZERO, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
